// File: rtl/decode_ctrl_pkg.sv
// Shared definitions for the decode stage: base opcodes, the immediate-type
// select encoding consumed by the immediate generator, and the buffer FSM states.
package decode_ctrl_pkg;

    // Base opcodes recognised by the decoder (inst[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // Immediate format select; IMM_IZ is the zero-extended I form used by SYSTEM
    typedef enum logic [2:0] {
        IMM_I  = 3'b000,
        IMM_S  = 3'b001,
        IMM_B  = 3'b010,
        IMM_J  = 3'b011,
        IMM_U  = 3'b100,
        IMM_IZ = 3'b101
    } imm_sel_e;

    // Occupancy of the head + skid buffer
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } state_e;

endpackage

// File: rtl/imm_sel_decoder.sv
// Opcode to immediate-type decode. Purely combinational; an invalid head
// never reports illegal so downstream logic can use the flag unqualified.
module imm_sel_decoder
    import decode_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic       valid,
    output imm_sel_e   imm_sel,
    output logic       illegal
);

    // Map the opcode to its immediate format and flag anything unrecognised
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        imm_sel = IMM_I;
        illegal = 1'b0;
        unique case (opcode)
            OP_LOAD, OP_IMM, OP_JALR, OP_REG: imm_sel = IMM_I;
            OP_STORE:                         imm_sel = IMM_S;
            OP_BRANCH:                        imm_sel = IMM_B;
            OP_JAL:                           imm_sel = IMM_J;
            OP_LUI, OP_AUIPC:                 imm_sel = IMM_U;
            OP_SYSTEM:                        imm_sel = IMM_IZ;
            default: begin
                imm_sel = IMM_I;
                illegal = valid;
            end
        endcase
    end

endmodule

// File: rtl/decode_ctrl.sv
// Decode-stage front end: a two-entry (head + skid) instruction buffer between
// fetch and execute, immediate-type decode of the head, and a saturating count
// of illegal instructions handed to execute.
module decode_ctrl
    import decode_ctrl_pkg::*;
#(
    parameter int DW = 32,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          if_valid,
    input  logic [DW-1:0] if_inst,
    input  logic [DW-1:0] if_pc,
    output logic          if_ready,
    output logic          id_valid,
    input  logic          ex_ready,
    output logic [DW-1:0] id_inst,
    output logic [DW-1:0] id_pc,
    output logic [2:0]    imm_sel,
    output logic          illegal,
    output logic [CW-1:0] illegal_cnt
);

    state_e        state, state_d;
    logic [DW-1:0] head_inst, head_pc;
    logic [DW-1:0] skid_inst, skid_pc;
    logic          push, pop;
    logic          load_head, head_from_skid, load_skid;
    imm_sel_e      sel;

    assign push = if_valid & if_ready;
    assign pop  = id_valid & ex_ready;

    // Next occupancy and which buffer slot captures what this cycle
    always_comb begin
        state_d        = state;
        load_head      = 1'b0;
        head_from_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            // Anything offered alongside a flush is dropped with the buffer
            state_d = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (push) begin
                        state_d   = ONE;
                        load_head = 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        load_head = 1'b1;
                    end else if (push) begin
                        state_d   = TWO;
                        load_skid = 1'b1;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    // if_ready is low here, so only a pop can happen
                    if (pop) begin
                        state_d        = ONE;
                        load_head      = 1'b1;
                        head_from_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Buffer FSM with registered handshake flags, entry storage and illegal counter
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state       <= EMPTY;
            id_valid    <= 1'b0;
            if_ready    <= 1'b1;
            illegal_cnt <= '0;
            // NOTE: the entry registers are reset too because id_inst/id_pc must read zero after reset.
            head_inst   <= '0;
            head_pc     <= '0;
            skid_inst   <= '0;
            skid_pc     <= '0;
        end else begin
            state    <= state_d;
            id_valid <= (state_d != EMPTY);
            if_ready <= (state_d != TWO);

            // A pop still retires its instruction even when flush is asserted
            if (pop && illegal && (illegal_cnt != '1))
                illegal_cnt <= illegal_cnt + CW'(1);

            if (load_head) begin
                head_inst <= head_from_skid ? skid_inst : if_inst;
                head_pc   <= head_from_skid ? skid_pc   : if_pc;
            end
            if (load_skid) begin
                skid_inst <= if_inst;
                skid_pc   <= if_pc;
            end
        end
    end

    assign id_inst = head_inst;
    assign id_pc   = head_pc;

    imm_sel_decoder u_imm_sel_decoder (
        .opcode  (head_inst[6:0]),
        .valid   (id_valid),
        .imm_sel (sel),
        .illegal (illegal)
    );

    assign imm_sel = sel;

endmodule

// File: tb/tb_decode_ctrl.sv
// Bench for decode_ctrl: a negedge monitor keeps a scoreboard of accepted
// instructions with their expected decode, compares each entry as execute
// consumes it and tracks the expected illegal count; scenario tasks add
// directed checks on handshake flags, ordering, flush and reset.
module tb_decode_ctrl;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [2:0]  sel;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_inst = '0;
    logic [31:0] if_pc = '0;
    logic        if_ready;
    logic        id_valid;
    logic        ex_ready = 1'b0;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [2:0]  imm_sel;
    logic        illegal;
    logic [7:0]  illegal_cnt;

    int          errors = 0;
    int          checks = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [7:0]  exp_cnt = '0;
    logic [31:0] pc_ctr = 32'h0000_1000;

    logic [31:0] prog [10] = '{32'h00500093, 32'h00112023, 32'hFE000EE3, 32'h0000006F,
                               32'h000012B7, 32'h00000073, 32'h002081B3, 32'h00012083,
                               32'h00008067, 32'h0000000B};

    decode_ctrl #(.DW(32), .CW(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .if_valid    (if_valid),
        .if_inst     (if_inst),
        .if_pc       (if_pc),
        .if_ready    (if_ready),
        .id_valid    (id_valid),
        .ex_ready    (ex_ready),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .imm_sel     (imm_sel),
        .illegal     (illegal),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    // Reference decode of the opcode field
    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc);
        exp_t e;
        e.inst = inst;
        e.pc   = pc;
        e.sel  = 3'b000;
        e.ill  = 1'b0;
        case (inst[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b0110011: e.sel = 3'b000;
            7'b0100011:             e.sel = 3'b001;
            7'b1100011:             e.sel = 3'b010;
            7'b1101111:             e.sel = 3'b011;
            7'b0110111, 7'b0010111: e.sel = 3'b100;
            7'b1110011:             e.sel = 3'b101;
            default:                e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // Scoreboard monitor: inputs are stable at negedge, so the handshakes seen
    // here are exactly the ones the next rising edge will act on
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            exp_cnt = '0;
        end else begin
            checks++;
            if (illegal_cnt !== exp_cnt) begin
                errors++;
                $display("FAIL illegal_cnt: got %0h expected %0h at %0t", illegal_cnt, exp_cnt, $time);
            end
            if (!id_valid) begin
                checks++;
                if (illegal !== 1'b0) begin
                    errors++;
                    $display("FAIL illegal_when_empty: got %b expected 0 at %0t", illegal, $time);
                end
            end
            if (id_valid && ex_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pop: inst %h pc %h with empty scoreboard at %0t", id_inst, id_pc, $time);
                end else begin
                    mon_e = sb.pop_front();
                    if (id_inst !== mon_e.inst || id_pc !== mon_e.pc ||
                        imm_sel !== mon_e.sel || illegal !== mon_e.ill) begin
                        errors++;
                        $display("FAIL pop_entry: got inst %h pc %h sel %b ill %b expected inst %h pc %h sel %b ill %b at %0t",
                                 id_inst, id_pc, imm_sel, illegal, mon_e.inst, mon_e.pc, mon_e.sel, mon_e.ill, $time);
                    end
                    if (mon_e.ill && exp_cnt != 8'hFF)
                        exp_cnt = exp_cnt + 8'd1;
                end
            end
            if (flush)
                sb.delete();
            else if (if_valid && if_ready)
                sb.push_back(model(if_inst, if_pc));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] inst);
        if_valid = 1'b1;
        if_inst  = inst;
        if_pc    = pc_ctr;
        pc_ctr   = pc_ctr + 32'd4;
    endtask

    task automatic idle_inputs();
        if_valid = 1'b0;
        if_inst  = '0;
        if_pc    = '0;
        flush    = 1'b0;
    endtask

    // Empty the buffer with a bounded wait
    task automatic drain(input string tag);
        int n;
        idle_inputs();
        ex_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (id_valid && n < 8) begin
            step();
            @(negedge clk);
            n++;
        end
        checks++;
        if (id_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: id_valid %b pending %0d expected 0/0", tag, id_valid, sb.size());
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        ex_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b0 || if_ready !== 1'b1 || illegal_cnt !== 8'h00 ||
            id_inst !== 32'h0 || id_pc !== 32'h0 || imm_sel !== 3'b000 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got v%b r%b cnt%h inst%h pc%h sel%b ill%b expected v0 r1 cnt00 inst0 pc0 sel000 ill0",
                     id_valid, if_ready, illegal_cnt, id_inst, id_pc, imm_sel, illegal);
        end
        step();
    endtask

    task automatic test_single();
        ex_ready = 1'b1;
        offer(32'h00500093);
        step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b1 || imm_sel !== 3'b000 || illegal !== 1'b0 || id_inst !== 32'h00500093) begin
            errors++;
            $display("FAIL single_latency: got v%b sel%b ill%b inst%h expected v1 sel000 ill0 inst00500093",
                     id_valid, imm_sel, illegal, id_inst);
        end
        step();
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_empty: id_valid got %b expected 0", id_valid);
        end
        step();
    endtask

    task automatic test_back_to_back();
        ex_ready = 1'b0;
        offer(32'h00112023);
        step();
        offer(32'hFE000EE3);
        step();
        offer(32'h00000013);
        @(negedge clk);
        checks++;
        if (if_ready !== 1'b0 || id_valid !== 1'b1 || id_inst !== 32'h00112023) begin
            errors++;
            $display("FAIL b2b_full: got r%b v%b inst%h expected r0 v1 inst00112023", if_ready, id_valid, id_inst);
        end
        step();
        @(negedge clk);
        checks++;
        if (id_inst !== 32'h00112023 || if_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_hold: got inst%h r%b expected inst00112023 r0", id_inst, if_ready);
        end
        step();
        idle_inputs();
        ex_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (imm_sel !== 3'b001 || id_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: got sel%b v%b expected sel001 v1", imm_sel, id_valid);
        end
        step();
        @(negedge clk);
        checks++;
        if (imm_sel !== 3'b010 || id_valid !== 1'b1 || if_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: got sel%b v%b r%b expected sel010 v1 r1", imm_sel, id_valid, if_ready);
        end
        drain("b2b");
    endtask

    task automatic test_stream();
        ex_ready = 1'b1;
        offer(32'h0000006F);
        step();
        offer(32'h000012B7);
        @(negedge clk);
        checks++;
        if (imm_sel !== 3'b011 || id_valid !== 1'b1 || if_ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_j: got sel%b v%b r%b expected sel011 v1 r1", imm_sel, id_valid, if_ready);
        end
        step();
        offer(32'h00000073);
        @(negedge clk);
        checks++;
        if (imm_sel !== 3'b100 || id_valid !== 1'b1 || if_ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_u: got sel%b v%b r%b expected sel100 v1 r1", imm_sel, id_valid, if_ready);
        end
        step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (imm_sel !== 3'b101 || id_valid !== 1'b1) begin
            errors++;
            $display("FAIL stream_iz: got sel%b v%b expected sel101 v1", imm_sel, id_valid);
        end
        drain("stream");
    endtask

    task automatic test_random_traffic();
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 3) != 0)
                offer(prog[$urandom_range(0, 9)]);
            else
                if_valid = 1'b0;
            ex_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        drain("random");
    endtask

    task automatic test_flush();
        ex_ready = 1'b0;
        offer(32'h00500093);
        step();
        offer(32'h00112023);
        step();
        flush = 1'b1;
        offer(32'h123450B7);
        step();
        idle_inputs();
        ex_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b0 || if_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_two: got v%b r%b expected v0 r1", id_valid, if_ready);
        end
        step();
        step();
        // Flush in ONE with an offered push and a consumed illegal head
        ex_ready = 1'b0;
        offer(32'hFFFFFFFF);
        step();
        flush = 1'b1;
        ex_ready = 1'b1;
        offer(32'h00500093);
        step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b0 || if_ready !== 1'b1 || exp_cnt == 8'h00) begin
            errors++;
            $display("FAIL flush_one: got v%b r%b cnt%h expected v0 r1 cnt nonzero", id_valid, if_ready, illegal_cnt);
        end
        step();
        drain("flush");
    endtask

    task automatic test_saturate();
        ex_ready = 1'b1;
        for (int i = 0; i < 257; i++) begin
            offer(32'hFFFFFFFF);
            if (i > 0) begin
                @(negedge clk);
                checks++;
                if (illegal !== 1'b1 || id_valid !== 1'b1 || imm_sel !== 3'b000) begin
                    errors++;
                    $display("FAIL sat_illegal[%0d]: got ill%b v%b sel%b expected ill1 v1 sel000", i, illegal, id_valid, imm_sel);
                end
            end
            step();
        end
        drain("sat");
        @(negedge clk);
        checks++;
        if (illegal_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL sat_count: got %h expected ff", illegal_cnt);
        end
        step();
    endtask

    task automatic test_reset_mid();
        ex_ready = 1'b0;
        offer(32'hFFFFFFFF);
        step();
        offer(32'hFFFFFFFF);
        step();
        rst = 1'b1;
        ex_ready = 1'b1;
        offer(32'h00500093);
        step();
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b0 || if_ready !== 1'b1 || illegal_cnt !== 8'h00 ||
            id_inst !== 32'h0 || id_pc !== 32'h0 || imm_sel !== 3'b000 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got v%b r%b cnt%h inst%h pc%h sel%b ill%b expected v0 r1 cnt00 inst0 pc0 sel000 ill0",
                     id_valid, if_ready, illegal_cnt, id_inst, id_pc, imm_sel, illegal);
        end
        step();
        step();
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_idle: v%b pending %0d expected 0/0", id_valid, sb.size());
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stream();
        test_random_traffic();
        test_flush();
        test_saturate();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
